// File: rtl/seg7_scan_m.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_m
//  Purpose  : Multiplexed 7-segment display scanner. Cycles through
//             NUM_DIGITS digits, holding each one lit for REFRESH_DIV clocks.
//             New values are double-buffered. A load lands in a pending
//             register and is committed only at a frame boundary, so the
//             display never tears mid-frame. Supports leading-zero
//             suppression, per-digit decimal points, blanking and selectable
//             output polarity.
//  Ports    : clk_i    - clock, all state on rising edge
//             rst_n_i  - asynchronous active-low reset
//             value_i  - 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//             load_i   - one-cycle strobe, captures value_i
//             dp_i     - per-digit decimal-point enable (live)
//             lzs_i    - leading-zero suppression enable (live)
//             blank_i  - force all digits dark (live)
//             seg_o    - segments {g,f,e,d,c,b,a}
//             dp_o     - decimal-point segment
//             an_o     - one-hot digit enable
//             frame_o  - one-cycle pulse after each frame boundary
//             upd_o    - one-cycle pulse after the display register updates
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_m #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lzs_i,
    input  logic                    blank_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o,
    output logic                    upd_o
);

    // A fixed 3-bit index covers up to 8 digits and stays legal for NUM_DIGITS=1.
    localparam int                c_IDX_W = 3;
    localparam int                c_PW    = $clog2(REFRESH_DIV);
    localparam logic [c_PW-1:0]   c_TC    = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_DIGITS - 1);
    // XOR mask that converts active-high drive to the pin polarity.
    localparam logic              c_POL   = (ACTIVE_LOW != 0);

    logic [c_PW-1:0]         r_presc;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_vld;

    logic                    w_tc;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_supp_vec;
    logic                    w_zero_run;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_supp_sel;
    logic [NUM_DIGITS-1:0]   w_an_hi;
    logic                    w_dark;
    logic [6:0]              w_seg_hi;
    logic                    w_dp_hi;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign w_tc        = (r_presc == c_TC);
    assign w_frame_end = w_tc && (r_idx == c_LAST);

    // Prescaler, digit index and frame pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_presc <= '0;
            r_idx   <= '0;
            frame_o <= 1'b0;
        end else begin
            frame_o <= w_frame_end;
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Double buffer. The display register only changes at a frame boundary.
    // A load that coincides with the boundary bypasses the pending register,
    // so it costs no extra frame of latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            upd_o      <= 1'b0;
        end else begin
            upd_o <= 1'b0;
            if (w_frame_end && load_i) begin
                r_disp     <= value_i;
                r_pend_vld <= 1'b0;
                upd_o      <= 1'b1;
            end else if (w_frame_end && r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= 1'b0;
                upd_o      <= 1'b1;
            end else if (load_i) begin
                r_pend     <= value_i;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Digit k is a leading zero when it and every higher digit are zero.
    // Digit 0 is always shown.
    always_comb begin
        w_supp_vec = '0;
        w_zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            w_zero_run    = w_zero_run & (r_disp[d*4 +: 4] == 4'h0);
            w_supp_vec[d] = (d != 0) && w_zero_run;
        end
    end

    // Select the data for the currently scanned digit.
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_supp_sel = 1'b0;
        w_an_hi    = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == c_IDX_W'(d)) begin
                w_nib      = r_disp[d*4 +: 4];
                w_dp_sel   = dp_i[d];
                w_supp_sel = w_supp_vec[d] & lzs_i;
                w_an_hi[d] = 1'b1;
            end
        end
    end

    assign w_dark   = blank_i | w_supp_sel;
    assign w_seg_hi = w_dark ? 7'h00 : f_glyph(w_nib);
    assign w_dp_hi  = ~w_dark & w_dp_sel;

    // Registered pin stage. Reset and blanking both mean "everything dark".
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_o <= {7{c_POL}};
            dp_o  <= c_POL;
            an_o  <= {NUM_DIGITS{c_POL}};
        end else begin
            seg_o <= w_seg_hi ^ {7{c_POL}};
            dp_o  <= w_dp_hi ^ c_POL;
            an_o  <= (blank_i ? '0 : w_an_hi) ^ {NUM_DIGITS{c_POL}};
        end
    end

endmodule
`default_nettype wire
